// File: rtl/mult_seq.sv
// rtl/mult_seq.sv - sequential unsigned shift-add multiplier with Go/Done handshake
//
// Purpose: multiplies two WIDTH-bit unsigned operands, one partial-product bit
// per clock, and presents the same Go/Done handshake as the shift-subtract divider.
//
// Ports:
//   CLK   in   1         system clock, rising edge
//   rst   in   1         synchronous, active-high reset
//   Go    in   1         start request, sampled only in IDLE
//   A     in   WIDTH     multiplicand, captured on the accepted-Go edge
//   B     in   WIDTH     multiplier, captured on the accepted-Go edge
//   P     out  2*WIDTH   product register, held until the next result
//   Busy  out  1         high whenever not IDLE
//   Done  out  1         one-cycle pulse, result valid in P
//
// Optional build macro: MULT_SEQ_ZERO_SKIP_EN (zero operand bypasses LOOP).

module mult_seq #(
    parameter int WIDTH = 4
) (
    input  logic                 CLK,
    input  logic                 rst,
    input  logic                 Go,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   P,
    output logic                 Busy,
    output logic                 Done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        LOOP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_sum;
    logic [WIDTH-1:0]     mreg;
    logic [CW-1:0]        cnt;

    // Accumulator value after this cycle's conditional add; also the value
    // written to P on the final iteration so the last add is not lost.
    assign acc_sum = mreg[0] ? (acc + mcand) : acc;

`ifdef MULT_SEQ_ZERO_SKIP_EN
    logic zero_op;
    // mcand still holds the unshifted A while in LOAD.
    assign zero_op = (mcand == '0) || (mreg == '0);
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (Go) state_nxt = LOAD;
`ifdef MULT_SEQ_ZERO_SKIP_EN
            LOAD: state_nxt = zero_op ? DONE : LOOP;
`else
            LOAD: state_nxt = LOOP;
`endif
            LOOP: if (cnt == CNT_LAST) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state <= IDLE;
            P     <= '0;
            acc   <= '0;
            mcand <= '0;
            mreg  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (Go) begin
                        mcand <= {{WIDTH{1'b0}}, A};
                        mreg  <= B;
                    end
                end
                LOAD: begin
                    acc <= '0;
                    cnt <= CNT_INIT;
`ifdef MULT_SEQ_ZERO_SKIP_EN
                    if (zero_op) P <= '0;
`endif
                end
                LOOP: begin
                    acc   <= acc_sum;
                    mcand <= mcand << 1;
                    mreg  <= mreg >> 1;
                    cnt   <= cnt - CNT_LAST;
                    if (cnt == CNT_LAST) P <= acc_sum;
                end
                default: ;
            endcase
        end
    end

    assign Busy = (state != IDLE);
    assign Done = (state == DONE);

endmodule

// File: tb/tb_mult_seq.sv
// tb/tb_mult_seq.sv - self-checking bench for mult_seq with timeline reference model

module tb_mult_seq;

    localparam int W = 4;

`ifdef MULT_SEQ_ZERO_SKIP_EN
    localparam int ZLAT = 2;
`else
    localparam int ZLAT = W + 2;
`endif

    logic             CLK = 1'b0;
    logic             rst = 1'b1;
    logic             Go  = 1'b0;
    logic [W-1:0]     A   = '0;
    logic [W-1:0]     B   = '0;
    logic [2*W-1:0]   P;
    logic             Busy;
    logic             Done;

    logic             go8 = 1'b0;
    logic [7:0]       a8  = '0;
    logic [7:0]       b8  = '0;
    logic [15:0]      p8;
    logic             busy8;
    logic             done8;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    mult_seq #(.WIDTH(W)) dut (
        .CLK(CLK), .rst(rst), .Go(Go), .A(A), .B(B),
        .P(P), .Busy(Busy), .Done(Done)
    );

    mult_seq #(.WIDTH(8)) dut8 (
        .CLK(CLK), .rst(rst), .Go(go8), .A(a8), .B(b8),
        .P(p8), .Busy(busy8), .Done(done8)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle", name, act, exp);
        end
    endtask

    // Reference model: an operation is a timeline. Once accepted in an idle
    // cycle, it is busy until its completion cycle, which shows Done and
    // publishes A*B. Anything during the busy window is ignored.
    int             cyc = 0;
    bit             m_active = 0;
    int             m_done_at = 0;
    logic [2*W-1:0] m_pending = '0;
    logic [2*W-1:0] m_p = '0;
    bit             chk_en = 0;

    always @(posedge CLK) begin
        bit was_idle;
        cyc++;
        if (rst) begin
            m_active = 0;
            m_p      = '0;
        end else begin
            was_idle = !m_active;
            if (m_active && (cyc - 1 == m_done_at)) m_active = 0;
            if (was_idle && Go) begin
                m_active  = 1;
                m_pending = (2*W)'(A) * (2*W)'(B);
                m_done_at = cyc - 1 + (((A == 0) || (B == 0)) ? ZLAT : W + 2);
            end
            if (m_active && cyc == m_done_at) m_p = m_pending;
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check("model_busy", 64'(Busy), 64'(m_active));
            check("model_done", 64'(Done), 64'(m_active && cyc == m_done_at));
            check("model_p", 64'(P), 64'(m_p));
        end
    end

    int go_cyc;

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        Go = 1'b1; A = a; B = b; go_cyc = cyc;
        @(posedge CLK); #1;
        Go = 1'b0;
    endtask

    // Returns latency (Done cycle minus Go cycle), -1 on timeout; ends at the
    // negedge of the Done cycle.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (Done) begin
                lat = cyc - go_cyc;
                break;
            end
        end
    endtask

    task automatic to_next_cycle();
        @(posedge CLK); #1;
    endtask

    task automatic count_done(input int n, output int cnt_d);
        cnt_d = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            if (Done) cnt_d++;
        end
    endtask

    initial begin
        int lat;
        int nd;

        repeat (2) @(posedge CLK);
        #1 rst = 1'b0;
        @(negedge CLK);
        check("reset_p", 64'(P), 64'h0);
        check("reset_busy", 64'(Busy), 64'h0);
        check("reset_done", 64'(Done), 64'h0);
        chk_en = 1;
        to_next_cycle();

        // Basic product
        start_op(4'd13, 4'd11);
        @(negedge CLK);
        check("basic_busy_c1", 64'(Busy), 64'h1);
        wait_done(lat);
        check("basic_lat", 64'(lat), 64'd6);
        check("basic_p", 64'(P), 64'h8F);
        to_next_cycle();
        check("basic_p_held", 64'(P), 64'h8F);
        check("basic_idle", 64'(Busy), 64'h0);

        // Max operands then 1*1
        start_op(4'd15, 4'd15);
        wait_done(lat);
        check("max_lat", 64'(lat), 64'd6);
        check("max_p", 64'(P), 64'hE1);
        to_next_cycle();
        start_op(4'd1, 4'd1);
        wait_done(lat);
        check("one_p", 64'(P), 64'h01);
        to_next_cycle();

        // Zero operand
        start_op(4'd0, 4'd9);
        wait_done(lat);
        check("zero_lat", 64'(lat), 64'(ZLAT));
        check("zero_p", 64'(P), 64'h00);
        to_next_cycle();

        // Go/operand changes while busy are ignored
        start_op(4'd6, 4'd7);
        to_next_cycle();
        Go = 1'b1; A = 4'd3; B = 4'd3;
        to_next_cycle();
        to_next_cycle();
        to_next_cycle();
        Go = 1'b0;
        wait_done(lat);
        check("ignore_lat", 64'(lat), 64'd6);
        check("ignore_p", 64'(P), 64'd42);
        count_done(10, nd);
        check("ignore_no_second_done", 64'(nd), 64'd0);
        to_next_cycle();

        // Continuous Go: period W+3
        Go = 1'b1; A = 4'd5; B = 4'd3; go_cyc = cyc;
        wait_done(lat);
        check("cont_lat1", 64'(lat), 64'd6);
        check("cont_p1", 64'(P), 64'd15);
        wait_done(lat);
        check("cont_lat2", 64'(lat), 64'd13);
        wait_done(lat);
        check("cont_lat3", 64'(lat), 64'd20);
        check("cont_p3", 64'(P), 64'd15);
        Go = 1'b0;
        to_next_cycle();

        // Reset mid-operation
        start_op(4'd9, 4'd9);
        to_next_cycle();
        to_next_cycle();
        rst = 1'b1;
        to_next_cycle();
        rst = 1'b0;
        @(negedge CLK);
        check("rst_mid_p", 64'(P), 64'h0);
        check("rst_mid_busy", 64'(Busy), 64'h0);
        count_done(10, nd);
        check("rst_mid_no_done", 64'(nd), 64'd0);
        to_next_cycle();
        start_op(4'd9, 4'd9);
        wait_done(lat);
        check("rst_fresh_lat", 64'(lat), 64'd6);
        check("rst_fresh_p", 64'(P), 64'd81);
        to_next_cycle();

        // WIDTH=8 instance
        go8 = 1'b1; a8 = 8'd15; b8 = 8'd15; go_cyc = cyc;
        to_next_cycle();
        go8 = 1'b0;
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (done8) begin
                lat = cyc - go_cyc;
                break;
            end
        end
        check("w8_lat", 64'(lat), 64'd10);
        check("w8_p", 64'(p8), 64'h00E1);
        to_next_cycle();

        // Randomized traffic, checked cycle by cycle by the model
        for (int i = 0; i < 800; i++) begin
            Go  = ($urandom_range(0, 3) == 0);
            A   = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            B   = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            rst = ($urandom_range(0, 149) == 0);
            to_next_cycle();
        end
        rst = 1'b0;
        Go  = 1'b0;
        repeat (W + 6) to_next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_seq.md
Name: mult_seq

Overview:
- Sequential unsigned shift-add multiplier for the calculator's arithmetic unit.
- It is the multiply counterpart of the shift-subtract divider and presents the same Go/Done handshake to the top-level calculator FSM.
- Control FSM and datapath (multiplicand, multiplier, accumulator, iteration counter) live in one block.
- One partial-product bit is processed per clock.

Parameters:
- WIDTH, 4, operand width in bits; product is 2*WIDTH bits; WIDTH >= 2.

Ports:
- CLK   input   1         system clock, all state changes on rising edge
- rst   input   1         reset, synchronous, active-high
- Go    input   1         start request, sampled only in IDLE
- A     input   WIDTH     multiplicand, captured on the accepted-Go edge
- B     input   WIDTH     multiplier, captured on the accepted-Go edge
- P     output  2*WIDTH   product register, held until next result is written
- Busy  output  1         high whenever state != IDLE
- Done  output  1         one-cycle pulse, result valid in P

Behaviour:
- Reset: on a rising CLK edge with rst=1:
  - state <= IDLE; P, accumulator, multiplicand, multiplier and counter cleared to 0.
  - Done=0, Busy=0.
  - rst has priority over everything, including mid-operation; the in-flight operation is abandoned and no Done is issued.
- States: IDLE, LOAD, LOOP, DONE. Done and Busy are Moore outputs decoded from state only.
- IDLE:
  - Go=1 -> LOAD. On the same edge: mcand <= {WIDTH zeros, A} (2*WIDTH wide) and mreg <= B.
  - Go=0 -> stay.
- LOAD: acc <= 0, cnt <= WIDTH. Always -> LOOP.
- LOOP, each cycle:
  - if mreg[0]=1 then acc <= acc + mcand (2*WIDTH-bit add, cannot overflow);
  - mcand <= mcand << 1; mreg <= mreg >> 1; cnt <= cnt - 1.
  - When cnt=1 (last iteration): P <= final acc value (including this cycle's add), then -> DONE. Otherwise stay in LOOP.
- DONE: Done=1 for exactly one cycle. Always -> IDLE, regardless of Go.
- Latency: Go sampled high in IDLE in cycle 0 -> LOAD cycle 1 -> LOOP cycles 2..WIDTH+1 -> Done=1 in cycle WIDTH+2. WIDTH=4 gives Done in cycle 6.
- P changes only on the edge entering DONE (or on reset). It is stable from the Done cycle until the next result.
- Go while Busy=1 is ignored, with no queuing. A and B changes after the capture edge have no effect.
- Go held continuously high: DONE -> IDLE -> accepted again next cycle. Back-to-back period is WIDTH+3 cycles, with Busy low for exactly one cycle (IDLE) between operations.
- Counter width: clog2(WIDTH+1) bits. cnt never wraps below 1 inside LOOP.
- Unreachable state encodings -> IDLE on next edge.

Optional Feature:
- Macro: MULT_SEQ_ZERO_SKIP_EN.
- Defined:
  - In LOAD, if the captured A==0 or B==0: P <= 0 and go directly LOAD -> DONE, skipping LOOP.
  - Done then rises in cycle 2 after Go. Non-zero operands are unaffected.
- Undefined: zero operands take the full WIDTH-iteration path. P=0 and Done in cycle WIDTH+2.

Test Plan:
- Basic product: WIDTH=4, A=13, B=11, Go pulse in cycle 0 -> Busy high in cycles 1-6, Done=1 only in cycle 6, P=8'h8F (143) from cycle 6 onward.
- Max operands: A=15, B=15 -> P=8'hE1 (225) with Done in cycle 6. Then A=1, B=1 -> P=8'h01. Also run A=15, B=15 with WIDTH=8 (Done in cycle 10, P=16'h00E1).
- Zero operand: A=0, B=9.
  - Without MULT_SEQ_ZERO_SKIP_EN: Done in cycle 6, P=0.
  - With the macro: Done in cycle 2, P=0, LOOP never entered.
- Ignore rules: after an accepted Go (A=6, B=7), change A/B to 3/3 and pulse Go in cycles 2-4 -> single Done in cycle 6, P=42, no second Done.
- Continuous Go: Go tied high, A=5, B=3 -> Done every 7 cycles (cycles 6, 13, 20), P=15 each time, Busy low for exactly one cycle between operations.
- Reset mid-op: assert rst in cycle 3 of an A=9, B=9 operation -> from the next edge P=0, Busy=0, state IDLE, no Done. A fresh Go then yields P=81 after WIDTH+2 cycles.
